// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with input sync, mid-bit sampling, parity/framing checks
//  clk, rst_n (async active-low) | dataserial: raw idle-high line
//  data_out/parity_err/frame_err: last frame, loaded with the one-cycle data_valid strobe
//  busy: receiver is inside a frame
module uart_rx_param #(
  parameter int CLOCKS_PER_BIT = 217,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dataserial,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID = CNT_W'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic ODD = PARITY_MODE == 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [DATA_BITS-1:0] shift;
  logic sync1, rx_s, rx_prev, stop_idx, perr, ferr, done;
  logic bit_end, mid, last_stop;
  assign bit_end = cnt == BIT_END;
  assign mid = cnt == MID;
  assign last_stop = (STOP_BITS == 1) || stop_idx;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // Every later sample lands one bit period after the mid-start check, i.e. mid-bit;
  // leaving STOP at mid-stop-bit lets a directly following start bit be caught.
  always_comb begin
    state_n = state;
    done = 1'b0;
    case (state)
      IDLE:   if (rx_prev && !rx_s) state_n = START;
      START:  if (mid) state_n = rx_s ? IDLE : DATA;
      DATA:   if (bit_end && idx == LAST_IDX) state_n = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY: if (bit_end) state_n = STOP;
      STOP:   if (bit_end && last_stop) begin
        state_n = IDLE;
        done = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s <= 1'b1;
      rx_prev <= 1'b1;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
      stop_idx <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1 <= dataserial;
      rx_s <= sync1;
      rx_prev <= rx_s;
      cnt <= (state == IDLE || (state == START && mid) || bit_end) ? '0 : cnt + 1'b1;
      if (state == START) begin
        idx <= '0;
        perr <= 1'b0;
        ferr <= 1'b0;
        stop_idx <= 1'b0;
      end
      if (state == DATA && bit_end) begin
        shift[idx] <= rx_s;
        idx <= idx + 1'b1;
      end
      if (state == PARITY && bit_end) perr <= rx_s ^ (^shift) ^ ODD;
      if (state == STOP && bit_end) begin
        stop_idx <= 1'b1;
        if (!rx_s) ferr <= 1'b1;
      end
      data_valid <= done;
      // The final stop sample is folded in directly since ferr only updates on this same edge.
      if (done) begin
        data_out <= shift;
        parity_err <= perr;
        frame_err <= ferr | ~rx_s;
      end
    end
  end
endmodule
